// File: rtl/bus_write_pkg.sv
// Shared definitions for the bus write unit: state encoding, bus direction
// constants and default bus widths.
package bus_write_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    DUMMY = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bus_write_hold.sv
// Capture registers for the request address, write data and RMW old value.
// Synchronous active-low clear takes priority over load.
module bus_write_hold #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              clr_n_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] old_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] old_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] old_q;

  always_ff @(posedge clk_i) begin
    if (!clr_n_i) begin
      addr_q <= '0;
      data_q <= '0;
      old_q  <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      data_q <= data_i;
      old_q  <= old_i;
    end
  end

  assign addr_o = addr_q;
  assign data_o = data_q;
  assign old_o  = old_q;

endmodule

// File: rtl/bus_write_unit.sv
// Bus write sequencer: SETUP, optional RMW dummy write, stallable WRITE, DONE pulse.
// Define BUS_WRITE_RMW_EN to build in the read-modify-write dummy write cycle.
//
// state | meaning
// IDLE  | waiting for start_WR, bus in read direction
// SETUP | address driven, still reading
// DUMMY | write of the unmodified old value (RMW builds only), never stalls
// WRITE | write of the new value, held while BUS_RDY is low
// DONE  | one-cycle completion pulse
module bus_write_unit
  import bus_write_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              FSM_Signal,
  input  logic              reset_n,
  input  logic              start_WR,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              rmw_WR,
  input  logic [DATA_W-1:0] IN_OLD,
  input  logic              BUS_RDY,
  output logic [ADDR_W-1:0] BUS_ADDR,
  output logic [DATA_W-1:0] BUS_DATA,
  output logic              BUS_RW,
  output logic              busy_WR,
  output logic              done_WR
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] bus_data_q, bus_data_d;
  logic [DATA_W-1:0] data_hold, old_hold, old_src;
  logic              accept;
  logic              rmw_sel;

  assign accept = (state_q == IDLE) && start_WR;

`ifdef BUS_WRITE_RMW_EN
  logic rmw_q;

  always_ff @(posedge FSM_Signal) begin
    if (!reset_n)    rmw_q <= 1'b0;
    else if (accept) rmw_q <= rmw_WR;
  end

  assign rmw_sel = rmw_q;
  assign old_src = IN_OLD;
`else
  logic unused_rmw;

  assign unused_rmw = rmw_WR ^ (^IN_OLD);
  assign rmw_sel    = 1'b0;
  assign old_src    = '0;
`endif

  bus_write_hold #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_hold (
    .clk_i   (FSM_Signal),
    .clr_n_i (reset_n),
    .load_i  (accept),
    .addr_i  (IN_ADDR),
    .data_i  (IN_DATA),
    .old_i   (old_src),
    .addr_o  (BUS_ADDR),
    .data_o  (data_hold),
    .old_o   (old_hold)
  );

  always_ff @(posedge FSM_Signal) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bus_data_q <= '0;
    end else begin
      state_q    <= state_d;
      bus_data_q <= bus_data_d;
    end
  end

  // bus_data_q remembers the last driven value so BUS_DATA holds between writes
  always_comb begin
    state_d    = state_q;
    bus_data_d = bus_data_q;
    BUS_RW     = RW_READ;
    busy_WR    = 1'b1;
    done_WR    = 1'b0;
    case (state_q)
      IDLE: begin
        busy_WR = 1'b0;
        if (start_WR) state_d = SETUP;
      end
      SETUP: begin
        state_d = rmw_sel ? DUMMY : WRITE;
      end
      DUMMY: begin
        BUS_RW     = RW_WRITE;
        bus_data_d = old_hold;
        state_d    = WRITE;
      end
      WRITE: begin
        BUS_RW     = RW_WRITE;
        bus_data_d = data_hold;
        if (BUS_RDY) state_d = DONE;
      end
      DONE: begin
        done_WR = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy_WR = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign BUS_DATA = bus_data_d;

endmodule

// File: tb/tb_bus_write_unit.sv
// Self-checking bench for bus_write_unit; write cycles go through a scoreboard.
// Scenario set follows BUS_WRITE_RMW_EN (RMW vs. non-RMW build).
module tb_bus_write_unit;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_WR;
  logic [15:0] IN_ADDR;
  logic [7:0]  IN_DATA;
  logic        rmw_WR;
  logic [7:0]  IN_OLD;
  logic        BUS_RDY;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_DATA;
  logic        BUS_RW;
  logic        busy_WR;
  logic        done_WR;

  int  checks   = 0;
  int  failures = 0;
  wr_t exp_q[$];
  wr_t mon_e;

  always #5 clk = ~clk;

  bus_write_unit #(.ADDR_W(16), .DATA_W(8)) dut (
    .FSM_Signal (clk),
    .reset_n    (reset_n),
    .start_WR   (start_WR),
    .IN_ADDR    (IN_ADDR),
    .IN_DATA    (IN_DATA),
    .rmw_WR     (rmw_WR),
    .IN_OLD     (IN_OLD),
    .BUS_RDY    (BUS_RDY),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_DATA   (BUS_DATA),
    .BUS_RW     (BUS_RW),
    .busy_WR    (busy_WR),
    .done_WR    (done_WR)
  );

  // every cycle with BUS_RW low is one bus write and must match the next expected entry
  always @(negedge clk) begin
    if (BUS_RW === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h, no write expected", BUS_ADDR, BUS_DATA);
      end else begin
        mon_e = exp_q.pop_front();
        if (BUS_ADDR !== mon_e.addr || BUS_DATA !== mon_e.data) begin
          failures++;
          $display("FAIL write_cycle got addr=%h data=%h expected addr=%h data=%h",
                   BUS_ADDR, BUS_DATA, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // called right after the acceptance edge; n counts edges including acceptance
  task automatic wait_done(output int n);
    n = 1;
    while (done_WR !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start_WR = 1'b0; IN_ADDR = '0; IN_DATA = '0;
    rmw_WR = 1'b0; IN_OLD = '0; BUS_RDY = 1'b1;
    tick();
    tick();
    checks++;
    if ({BUS_RW, BUS_ADDR, BUS_DATA, busy_WR, done_WR} !== {1'b1, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got rw=%b addr=%h data=%h busy=%b done=%b expected rw=1 addr=0000 data=00 busy=0 done=0",
               BUS_RW, BUS_ADDR, BUS_DATA, busy_WR, done_WR);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if (busy_WR !== 1'b0 || BUS_RW !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b rw=%b expected busy=0 rw=1", busy_WR, BUS_RW);
    end
  endtask

  task automatic test_basic();
    int n;
    push_exp(16'h0200, 8'h5A);
    IN_ADDR = 16'h0200; IN_DATA = 8'h5A; BUS_RDY = 1'b1; start_WR = 1'b1;
    tick();
    start_WR = 1'b0;
    checks++;
    if (BUS_RW !== 1'b1 || BUS_ADDR !== 16'h0200 || busy_WR !== 1'b1) begin
      failures++;
      $display("FAIL basic_setup got rw=%b addr=%h busy=%b expected rw=1 addr=0200 busy=1",
               BUS_RW, BUS_ADDR, busy_WR);
    end
    wait_done(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL basic_latency got %0d edges expected 3", n);
    end
    checks++;
    if (BUS_RW !== 1'b1 || BUS_ADDR !== 16'h0200) begin
      failures++;
      $display("FAIL basic_done_bus got rw=%b addr=%h expected rw=1 addr=0200", BUS_RW, BUS_ADDR);
    end
    tick();
    checks++;
    if (busy_WR !== 1'b0 || done_WR !== 1'b0 || BUS_DATA !== 8'h5A || BUS_RW !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle got busy=%b done=%b data=%h rw=%b expected busy=0 done=0 data=5a rw=1",
               busy_WR, done_WR, BUS_DATA, BUS_RW);
    end
  endtask

  task automatic test_stall();
    repeat (5) push_exp(16'h1234, 8'hC3);
    IN_ADDR = 16'h1234; IN_DATA = 8'hC3; BUS_RDY = 1'b1; start_WR = 1'b1;
    tick();
    start_WR = 1'b0;
    BUS_RDY  = 1'b0;
    IN_DATA  = 8'hEE;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (BUS_RW !== 1'b0 || BUS_ADDR !== 16'h1234 || BUS_DATA !== 8'hC3 || done_WR !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] got rw=%b addr=%h data=%h done=%b expected rw=0 addr=1234 data=c3 done=0",
                 i, BUS_RW, BUS_ADDR, BUS_DATA, done_WR);
      end
      tick();
    end
    checks++;
    if (BUS_RW !== 1'b0 || done_WR !== 1'b0) begin
      failures++;
      $display("FAIL stall_last got rw=%b done=%b expected rw=0 done=0", BUS_RW, done_WR);
    end
    BUS_RDY = 1'b1;
    tick();
    checks++;
    if (done_WR !== 1'b1 || BUS_ADDR !== 16'h1234) begin
      failures++;
      $display("FAIL stall_release got done=%b addr=%h expected done=1 addr=1234", done_WR, BUS_ADDR);
    end
    tick();
  endtask

`ifdef BUS_WRITE_RMW_EN
  task automatic test_rmw();
    int n;
    push_exp(16'h00FF, 8'h80);
    push_exp(16'h00FF, 8'h00);
    IN_ADDR = 16'h00FF; IN_DATA = 8'h00; IN_OLD = 8'h80; rmw_WR = 1'b1;
    BUS_RDY = 1'b1; start_WR = 1'b1;
    tick();
    start_WR = 1'b0; rmw_WR = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL rmw_latency got %0d edges expected 4", n);
    end
    tick();
  endtask
`else
  task automatic test_no_rmw();
    int n;
    push_exp(16'hFFFF, 8'h3C);
    IN_ADDR = 16'hFFFF; IN_DATA = 8'h3C; IN_OLD = 8'h99; rmw_WR = 1'b1;
    BUS_RDY = 1'b1; start_WR = 1'b1;
    tick();
    start_WR = 1'b0; rmw_WR = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL no_rmw_latency got %0d edges expected 3", n);
    end
    checks++;
    if (BUS_ADDR !== 16'hFFFF) begin
      failures++;
      $display("FAIL no_rmw_addr got %h expected ffff", BUS_ADDR);
    end
    tick();
  endtask
`endif

  task automatic test_back_to_back();
    int n;
    push_exp(16'h0300, 8'h11);
    push_exp(16'h0300, 8'h15);
    IN_ADDR = 16'h0300; BUS_RDY = 1'b1; start_WR = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      IN_DATA = 8'h10 + 8'(k);
      tick();
      if (k == 3) begin
        checks++;
        if (done_WR !== 1'b1) begin
          failures++;
          $display("FAIL b2b_first_done got %b expected 1", done_WR);
        end
      end
      if (k == 4) begin
        checks++;
        if (busy_WR !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle_gap got busy=%b expected 0", busy_WR);
        end
      end
      if (k == 5) begin
        checks++;
        if (busy_WR !== 1'b1) begin
          failures++;
          $display("FAIL b2b_second_start got busy=%b expected 1", busy_WR);
        end
      end
    end
    start_WR = 1'b0;
    wait_done(n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_second_latency got %0d edges expected 3", n);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    push_exp(16'h0ABC, 8'h77);
    IN_ADDR = 16'h0ABC; IN_DATA = 8'h77; BUS_RDY = 1'b1; start_WR = 1'b1;
    tick();
    start_WR = 1'b0;
    BUS_RDY  = 1'b0;
    tick();
    checks++;
    if (BUS_RW !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_write got rw=%b expected 0", BUS_RW);
    end
    reset_n = 1'b0;
    start_WR = 1'b1;
    BUS_RDY  = 1'b1;
    tick();
    checks++;
    if ({BUS_RW, BUS_ADDR, BUS_DATA, busy_WR, done_WR} !== {1'b1, 16'h0000, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL abort_reset_values got rw=%b addr=%h data=%h busy=%b done=%b expected rw=1 addr=0000 data=00 busy=0 done=0",
               BUS_RW, BUS_ADDR, BUS_DATA, busy_WR, done_WR);
    end
    tick();
    start_WR = 1'b0;
    reset_n  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done_WR !== 1'b0 || busy_WR !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done[%0d] got done=%b busy=%b expected done=0 busy=0", i, done_WR, busy_WR);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
`ifdef BUS_WRITE_RMW_EN
    test_rmw();
`else
    test_no_rmw();
`endif
    test_back_to_back();
    test_reset_abort();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending writes expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_write_unit.md
BUS_WRITE_UNIT -- requirements
Module: bus_write_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address bus width.
REQ-002 SHALL have parameter DATA_W, default 8, data bus width.
REQ-003 SHALL have port FSM_Signal  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port start_WR  input  1  write request from control FSM.
REQ-006 SHALL have port IN_ADDR  input  ADDR_W  target address.
REQ-007 SHALL have port IN_DATA  input  DATA_W  value to store.
REQ-008 SHALL have port rmw_WR  input  1  read-modify-write request qualifier.
REQ-009 SHALL have port IN_OLD  input  DATA_W  unmodified operand for the RMW dummy write.
REQ-010 SHALL have port BUS_RDY  input  1  bus ready; low stretches the active write cycle.
REQ-011 SHALL have port BUS_ADDR  output  ADDR_W  bus address.
REQ-012 SHALL have port BUS_DATA  output  DATA_W  bus write data.
REQ-013 SHALL have port BUS_RW  output  1  bus direction; 1 = read, 0 = write.
REQ-014 SHALL have port busy_WR  output  1  high in every state except IDLE.
REQ-015 SHALL have port done_WR  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement a state machine with states IDLE, SETUP, DUMMY, WRITE and DONE.
REQ-017 SHALL accept start_WR only in IDLE, and SHALL latch IN_ADDR, IN_DATA, IN_OLD and rmw_WR on that edge.
REQ-018 SHALL ignore start_WR in all states other than IDLE, including DONE.
REQ-019 SHALL transition IDLE->SETUP on acceptance, with BUS_ADDR = latched address and BUS_RW = 1 in SETUP.
REQ-020 SHALL transition SETUP->WRITE, or SETUP->DUMMY when rmw is latched and RMW is compiled in.
REQ-021 SHALL in DUMMY drive BUS_RW = 0 and BUS_DATA = latched old value for exactly one cycle, then go to WRITE.
REQ-022 SHALL in WRITE drive BUS_RW = 0 and BUS_DATA = latched data, and hold WRITE while BUS_RDY = 0.
REQ-023 SHALL go WRITE->DONE on the first edge with BUS_RDY = 1.
REQ-024 SHALL in DONE assert done_WR = 1 and BUS_RW = 1 for one cycle, then return to IDLE.
REQ-025 SHALL give a non-RMW latency of 3 edges from acceptance to done_WR with BUS_RDY = 1; RMW adds one cycle.
REQ-026 SHALL keep BUS_ADDR stable from SETUP through DONE, and SHALL accept address 0xFFFF with no wrap or increment.
REQ-027 SHALL hold BUS_RW = 1 in IDLE, SETUP and DONE, so no write occurs outside DUMMY and WRITE.
REQ-028 SHALL keep BUS_DATA at the last driven value when not writing.
REQ-029 SHALL NOT stall DUMMY on BUS_RDY, because the 6502 never stalls writes of an RMW pair.

Reset
REQ-030 SHALL when reset_n = 0 at an edge enter IDLE and set BUS_RW = 1, BUS_ADDR = 0, BUS_DATA = 0, busy_WR = 0 and done_WR = 0.
REQ-031 SHALL give reset priority over start_WR and BUS_RDY.
REQ-032 SHALL abort any operation in progress on reset with no further write cycle, and SHALL NOT pulse done_WR for the aborted operation.

Configuration
REQ-033 SHALL, with BUS_WRITE_RMW_EN defined, perform the DUMMY write when rmw_WR is latched high.
REQ-034 SHALL, without BUS_WRITE_RMW_EN, ignore rmw_WR and IN_OLD, treat DUMMY as unreachable, and use plain SETUP->WRITE for every request.

Structure
REQ-035 SHALL take from the shared package bus_write_pkg the state encoding, the RW_READ/RW_WRITE constants, and the default ADDR_W/DATA_W values.
REQ-036 SHALL place the address, data and old-value capture registers in one sub-module, bus_write_hold, with load and synchronous active-low clear.

Verification
REQ-037 SHALL cover: reset, then start_WR with IN_ADDR = 0x0200, IN_DATA = 0x5A, BUS_RDY = 1 -> BUS_RW = 0 with BUS_DATA = 0x5A for one cycle at 0x0200, and done_WR 3 edges after acceptance.
REQ-038 SHALL cover: BUS_RDY held low 4 cycles in WRITE -> WRITE is held 4 extra cycles, address and data stable, and done_WR one edge after BUS_RDY rises.
REQ-039 SHALL cover (macro defined): rmw_WR = 1, IN_OLD = 0x80, IN_DATA = 0x00, addr 0x00FF -> writes 0x80 then 0x00 on consecutive cycles, and done_WR 4 edges after acceptance.
REQ-040 SHALL cover: start_WR held high through the whole operation with changing IN_DATA -> the first value is written once and a second operation starts only after return to IDLE.
REQ-041 SHALL cover: reset_n = 0 during WRITE -> BUS_RW = 1 next edge, no done_WR, and all outputs at reset values.
REQ-042 SHALL cover (macro undefined): rmw_WR = 1, addr 0xFFFF -> single write only, at 0xFFFF, with the non-RMW latency.
